// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: decodes ALUOp/funct3/funct7/op into an ALU control code,
// holds the EX-stage control register and sequences multi-cycle MD ops.
// Ports: clk, rst (async, active-high); id_valid, alu_op, funct3, funct7,
//   op from decode; stall_in, flush from hazard/branch logic; ex_alu_ctrl,
//   ex_valid, ex_is_md, ex_illegal to execute; md_start, md_busy, stall_out
//   to the MD datapath and hazard unit.
// Build option: define ALU_CTRL_RV32M_EN to include the RV32M decode and
//   the multiply/divide sequencer; otherwise MUL/DIV decode as illegal.
module alu_ctrl_pipe #(
   parameter int CTRL_W     = 5,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [1:0]        alu_op,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [6:0]        op,
   input  logic              stall_in,
   input  logic              flush,
   output logic [CTRL_W-1:0] ex_alu_ctrl,
   output logic              ex_valid,
   output logic              ex_is_md,
   output logic              ex_illegal,
   output logic              md_start,
   output logic              md_busy,
   output logic              stall_out
);

   localparam logic [4:0] C_ADD  = 5'b00000;
   localparam logic [4:0] C_SUB  = 5'b00001;
   localparam logic [4:0] C_AND  = 5'b00010;
   localparam logic [4:0] C_OR   = 5'b00011;
   localparam logic [4:0] C_XOR  = 5'b00100;
   localparam logic [4:0] C_SLT  = 5'b00101;
   localparam logic [4:0] C_SLTU = 5'b00110;
   localparam logic [4:0] C_SLL  = 5'b00111;
   localparam logic [4:0] C_SRL  = 5'b01000;
   localparam logic [4:0] C_SRA  = 5'b01001;

   logic [4:0] dec_code;
   logic       dec_ill;
   logic       dec_md;
   logic       hold;
   logic       load;

   logic unused_ok;
   assign unused_ok = &{1'b0, op[6], op[4:0]};

   always_comb begin
      dec_code = C_ADD;
      dec_ill  = 1'b0;
      dec_md   = 1'b0;
      unique case (alu_op)
         2'b00: dec_code = C_ADD;
         2'b01: dec_code = C_SUB;
         2'b11: dec_ill  = 1'b1;
         default: begin
            unique case (funct3)
               3'b000: dec_code = (op[5] & funct7[5]) ? C_SUB : C_ADD;
               3'b001: dec_code = C_SLL;
               3'b010: dec_code = C_SLT;
               3'b011: dec_code = C_SLTU;
               3'b100: dec_code = C_XOR;
               3'b101: dec_code = funct7[5] ? C_SRA : C_SRL;
               3'b110: dec_code = C_OR;
               default: dec_code = C_AND;
            endcase
            // R-type only: funct7 must be one of the three legal encodings
            if (op[5]) begin
               if (funct7 == 7'b0000001) begin
`ifdef ALU_CTRL_RV32M_EN
                  dec_md   = 1'b1;
                  dec_code = {2'b10, funct3};
`else
                  dec_ill  = 1'b1;
`endif
               end else if (funct7 == 7'b0100000) begin
                  if (funct3 != 3'b000 && funct3 != 3'b101)
                     dec_ill = 1'b1;
               end else if (funct7 != 7'b0000000) begin
                  dec_ill = 1'b1;
               end
            end
            if (dec_ill)
               dec_code = C_ADD;
         end
      endcase
   end

   assign hold = stall_in | stall_out;
   assign load = ~flush & ~hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_alu_ctrl <= '0;
         ex_valid    <= 1'b0;
         ex_is_md    <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid    <= 1'b0;
         ex_is_md    <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (!hold) begin
         ex_alu_ctrl <= CTRL_W'(dec_code);
         ex_valid    <= id_valid;
         ex_is_md    <= id_valid & dec_md;
         ex_illegal  <= id_valid & dec_ill;
      end
   end

`ifdef ALU_CTRL_RV32M_EN
   localparam int MAXL = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
   localparam logic [CW-1:0] MUL_L = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_L = CW'(DIV_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          md_load;

   assign md_load   = load & id_valid & dec_md;
   assign md_busy   = (state == RUN);
   // cnt counts the cycles still to go before the op may leave EX
   assign stall_out = (state == RUN) && (cnt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         md_start <= 1'b0;
      end else begin
         md_start <= md_load;
         if (flush) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (md_load) begin
            state <= RUN;
            cnt   <= funct3[2] ? DIV_L : MUL_L;
         end else if (state == RUN) begin
            if (cnt != '0)
               cnt <= cnt - 1'b1;
            else if (!stall_in)
               state <= IDLE;
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = (MUL_CYCLES > DIV_CYCLES) | dec_md;
   assign md_start   = 1'b0;
   assign md_busy    = 1'b0;
   assign stall_out  = 1'b0;
`endif

endmodule
